// File: rtl/imem_responder_if.sv
// Fetch-side bus of the instruction memory responder.
// Request/response handshakes plus the byte-strobed program-load port.
interface imem_responder_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              req_valid_i;
  logic              req_ready_o;
  logic [AWIDTH-1:0] req_addr_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DWIDTH-1:0] rsp_data_o;
  logic [AWIDTH-1:0] rsp_addr_o;
  logic              rsp_err_o;
  logic              wr_en_i;
  logic [AWIDTH-1:0] wr_addr_i;
  logic [DWIDTH-1:0] wr_data_i;
  logic [DWIDTH/8-1:0] wr_strb_i;

  modport slave (
    input  req_valid_i, req_addr_i, rsp_ready_i,
    input  wr_en_i, wr_addr_i, wr_data_i, wr_strb_i,
    output req_ready_o, rsp_valid_o, rsp_data_o,
    output rsp_addr_o, rsp_err_o
  );

  modport master (
    output req_valid_i, req_addr_i, rsp_ready_i,
    output wr_en_i, wr_addr_i, wr_data_i, wr_strb_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o,
    input  rsp_addr_o, rsp_err_o
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction memory responder: in-order pipelined word reads
// behind a credit-limited response FIFO, plus a strobed write port.
module imem_responder #(
  parameter int              DWIDTH     = 32,
  parameter int              AWIDTH     = 32,
  parameter logic [AWIDTH-1:0] BASEADDR = 32'h0100_0000,
  parameter int              MEM_BYTES  = 4096,
  parameter int              LATENCY    = 2,
  parameter int              FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  imem_responder_if.slave bus
);

  localparam int NB    = DWIDTH / 8;
  localparam int WORDS = MEM_BYTES / 4;
  localparam int IW    = $clog2(WORDS);
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH + LATENCY + 1);

  typedef logic [AWIDTH:0] ext_t;

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] data;
  } stage_t;

  logic [DWIDTH-1:0] mem_q [WORDS];

  ext_t          roff;
  logic          rerr;
  logic [IW-1:0] ridx;
  ext_t          woff;
  logic          wok;
  logic [IW-1:0] widx;

  logic          ready;
  logic          accept;
  stage_t        acc_s;
  stage_t        push_s;
  logic [CW-1:0] inflight;

  logic [DWIDTH-1:0] fdata_q [FIFO_DEPTH];
  logic [AWIDTH-1:0] faddr_q [FIFO_DEPTH];
  logic              ferr_q  [FIFO_DEPTH];
  logic [PW-1:0]     wptr_q, wptr_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push;
  logic              pop;
  logic              rsp_v;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Extended width keeps out-of-range offsets from wrapping.
  always_comb begin
    roff = {1'b0, bus.req_addr_i} - {1'b0, BASEADDR};
    rerr = (|bus.req_addr_i[1:0])
         || (bus.req_addr_i < BASEADDR)
         || ((roff + ext_t'(4)) > ext_t'(MEM_BYTES));
    ridx = roff[IW+1:2];
  end

  always_comb begin
    woff = {1'b0, bus.wr_addr_i} - {1'b0, BASEADDR};
    wok  = !(bus.wr_addr_i < BASEADDR)
        && (((woff & ~ext_t'(3)) + ext_t'(4))
            <= ext_t'(MEM_BYTES));
    widx = woff[IW+1:2];
  end

  always_ff @(posedge clk) begin
    if (bus.wr_en_i && wok) begin
      for (int b = 0; b < NB; b++) begin
        if (bus.wr_strb_i[b]) begin
          mem_q[widx][8*b +: 8] <= bus.wr_data_i[8*b +: 8];
        end
      end
    end
  end

  assign ready  = (inflight + count_q) < CW'(FIFO_DEPTH);
  assign accept = bus.req_valid_i && ready;

  always_comb begin
    acc_s.valid = accept;
    acc_s.err   = rerr;
    acc_s.addr  = bus.req_addr_i;
    acc_s.data  = rerr ? '0 : mem_q[ridx];
  end

  // The FIFO write is the last of the LATENCY register stages.
  if (LATENCY == 1) begin : g_direct
    assign push_s   = acc_s;
    assign inflight = '0;
  end else begin : g_pipe
    stage_t pipe_q [LATENCY-1];
    stage_t pipe_d [LATENCY-1];

    always_comb begin
      pipe_d[0] = acc_s;
      for (int i = 1; i < LATENCY - 1; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < LATENCY - 1; i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        pipe_q <= pipe_d;
      end
    end

    always_comb begin
      inflight = '0;
      for (int i = 0; i < LATENCY - 1; i++) begin
        inflight = inflight + CW'(pipe_q[i].valid);
      end
    end

    assign push_s = pipe_q[LATENCY-2];
  end

  assign push  = push_s.valid;
  assign rsp_v = (count_q != '0);
  assign pop   = rsp_v && bus.rsp_ready_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = nxt(wptr_q);
    if (pop)  rptr_d = nxt(rptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fdata_q[wptr_q] <= push_s.data;
      faddr_q[wptr_q] <= push_s.addr;
      ferr_q[wptr_q]  <= push_s.err;
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.rsp_valid_o = rsp_v;
  assign bus.rsp_data_o  = rsp_v ? fdata_q[rptr_q] : '0;
  assign bus.rsp_addr_o  = rsp_v ? faddr_q[rptr_q] : '0;
  assign bus.rsp_err_o   = rsp_v && ferr_q[rptr_q];

endmodule
